// File: rtl/rv32i_data_mem_if.sv
// rtl/rv32i_data_mem_if.sv - request/response bus between the core MEM stage and the data memory
interface rv32i_data_mem_if #(
  parameter int DLEN = 32,
  parameter int AW   = 12
);
  logic            req_valid;
  logic            req_ready;
  logic            req_we;
  logic [AW-1:0]   req_addr;
  logic [1:0]      req_size;
  logic            req_unsigned;
  logic [DLEN-1:0] req_wdata;
  logic            rsp_valid;
  logic [DLEN-1:0] rsp_rdata;
  logic            rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/rv32i_data_mem.sv
// rtl/rv32i_data_mem.sv - byte-addressed data memory with sub-word load/store and pipelined response
module rv32i_data_mem #(
  parameter int DLEN       = 32,
  parameter int DEPTH      = 1024,
  parameter int AW         = $clog2(DEPTH*DLEN/8),
  parameter int LATENCY    = 1,
  parameter bit INIT_CLEAR = 1'b1
) (
  input  logic            clk,
  input  logic            aresetn,
  rv32i_data_mem_if.slave bus
);
  localparam int NB    = DLEN / 8;
  localparam int OFFW  = $clog2(NB);
  localparam int WIDXW = AW - OFFW;
  localparam int IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {ST_INIT, ST_RUN} state_e;

  state_e                          state_q;
  logic                            ready_q;
  logic [IW-1:0]                   cnt_q;
  logic [DLEN-1:0]                 mem_q [DEPTH];

  logic [LATENCY-1:0]              vld_q;
  logic [LATENCY-1:0]              err_q;
  logic [LATENCY-1:0][DLEN-1:0]    dat_q;

  logic [OFFW-1:0]                 off;
  logic [WIDXW-1:0]                widx;
  logic [IW-1:0]                   ridx;
  logic                            in_range;
  logic                            misaligned;
  logic                            acc_err;
  logic                            accept;
  logic                            do_store;
  logic [NB-1:0]                   be;
  logic [DLEN-1:0]                 wlane;
  logic [DLEN-1:0]                 rword;
  logic [DLEN-1:0]                 rshift;
  logic [DLEN-1:0]                 ld_data;
  logic                            sbit;
  int                              nbits;
  int                              nbytes;

  // Address split: byte lane within the word, and word index into the array.
  assign off      = bus.req_addr[OFFW-1:0];
  assign widx     = bus.req_addr[AW-1:OFFW];
  assign ridx     = widx[IW-1:0];
  assign in_range = (32'(widx) < 32'(DEPTH));

  assign accept   = bus.req_valid && ready_q;
  assign acc_err  = misaligned || !in_range;
  assign do_store = accept && bus.req_we && !acc_err;

  // Alignment and size legality; a double access only exists on a 64-bit array.
  always_comb begin
    misaligned = 1'b0;
    case (bus.req_size)
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = off[0];
      2'b10:   misaligned = |off[1:0];
      default: misaligned = (DLEN != 64) || (|off);
    endcase
  end

  // Store lanes: data moved up to the addressed byte, enables cover exactly the access width.
  always_comb begin
    nbytes = 32'(1) << bus.req_size;
    be     = '0;
    for (int b = 0; b < NB; b++) begin
      be[b] = (b >= int'(off)) && (b < int'(off) + nbytes);
    end
    wlane = bus.req_wdata << {off, 3'b000};
  end

  // Load path: the array is read combinationally so a load sees any store committed on an earlier edge.
  always_comb begin
    rword  = mem_q[ridx];
    rshift = rword >> {off, 3'b000};
    nbits  = DLEN;
    sbit   = 1'b0;
    case (bus.req_size)
      2'b00:   begin nbits = 8;  sbit = rshift[7];  end
      2'b01:   begin nbits = 16; sbit = rshift[15]; end
      2'b10:   begin nbits = 32; sbit = rshift[31]; end
      default: begin nbits = DLEN; sbit = 1'b0; end
    endcase
    if (bus.req_unsigned) sbit = 1'b0;
    for (int i = 0; i < DLEN; i++) begin
      ld_data[i] = (i < nbits) ? rshift[i] : sbit;
    end
  end

  // INIT/RUN control: walk the clear counter over every word, then accept requests every cycle.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= INIT_CLEAR ? ST_INIT : ST_RUN;
      ready_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        ST_INIT: begin
          ready_q <= 1'b0;
          if (cnt_q == IW'(DEPTH - 1)) begin
            state_q <= ST_RUN;
            ready_q <= 1'b1;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  // Storage array: zeroed one word per cycle during INIT, otherwise byte-enabled stores.
  always_ff @(posedge clk) begin
    if (state_q == ST_INIT) begin
      mem_q[cnt_q] <= '0;
    end else if (do_store) begin
      for (int b = 0; b < NB; b++) begin
        if (be[b]) mem_q[ridx][8*b +: 8] <= wlane[8*b +: 8];
      end
    end
  end

  // Response shift pipeline; idle stages carry zero data so the outputs read 0 when nothing is due.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      vld_q <= '0;
      err_q <= '0;
      dat_q <= '0;
    end else begin
      for (int i = LATENCY - 1; i > 0; i--) begin
        vld_q[i] <= vld_q[i-1];
        err_q[i] <= err_q[i-1];
        dat_q[i] <= dat_q[i-1];
      end
      vld_q[0] <= accept;
      err_q[0] <= accept && acc_err;
      dat_q[0] <= (accept && !bus.req_we && !acc_err) ? ld_data : '0;
    end
  end

  assign bus.req_ready = ready_q;
  assign bus.rsp_valid = vld_q[LATENCY-1];
  assign bus.rsp_err   = err_q[LATENCY-1];
  assign bus.rsp_rdata = dat_q[LATENCY-1];

endmodule

// File: tb/tb_rv32i_data_mem.sv
// tb/tb_rv32i_data_mem.sv - directed self-checking bench for rv32i_data_mem
module tb_rv32i_data_mem;
  logic clk;
  logic aresetn;
  int   vectors;
  int   miscompares;

  rv32i_data_mem_if #(.DLEN(32), .AW(8)) ia ();
  rv32i_data_mem_if #(.DLEN(32), .AW(8)) ib ();
  rv32i_data_mem_if #(.DLEN(32), .AW(8)) ic ();

  rv32i_data_mem #(.DLEN(32), .DEPTH(16), .AW(8), .LATENCY(1), .INIT_CLEAR(1'b1))
    u_a (.clk(clk), .aresetn(aresetn), .bus(ia));
  rv32i_data_mem #(.DLEN(32), .DEPTH(16), .AW(8), .LATENCY(3), .INIT_CLEAR(1'b1))
    u_b (.clk(clk), .aresetn(aresetn), .bus(ib));
  rv32i_data_mem #(.DLEN(32), .DEPTH(16), .AW(8), .LATENCY(2), .INIT_CLEAR(1'b1))
    u_c (.clk(clk), .aresetn(aresetn), .bus(ic));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One request on the LATENCY=1 instance; called at a negedge, returns at a negedge.
  task automatic a_req(input string tag, input logic we, input logic [7:0] addr,
                       input logic [1:0] size, input logic uns, input logic [31:0] wd,
                       input logic [31:0] exp_d, input logic exp_e);
    ia.req_valid = 1'b1; ia.req_we = we; ia.req_addr = addr;
    ia.req_size = size; ia.req_unsigned = uns; ia.req_wdata = wd;
    @(posedge clk); @(negedge clk);
    ia.req_valid = 1'b0;
    chk({tag, ".valid"}, 64'(ia.rsp_valid), 64'(1));
    chk({tag, ".rdata"}, 64'(ia.rsp_rdata), 64'(exp_d));
    chk({tag, ".err"},   64'(ia.rsp_err),   64'(exp_e));
  endtask

  // One request on the LATENCY=2 instance.
  task automatic c_req(input string tag, input logic we, input logic [7:0] addr,
                       input logic [1:0] size, input logic [31:0] wd, input logic [31:0] exp_d);
    ic.req_valid = 1'b1; ic.req_we = we; ic.req_addr = addr;
    ic.req_size = size; ic.req_unsigned = 1'b0; ic.req_wdata = wd;
    @(posedge clk); @(negedge clk);
    ic.req_valid = 1'b0;
    chk({tag, ".early"}, 64'(ic.rsp_valid), 64'(0));
    @(posedge clk); @(negedge clk);
    chk({tag, ".valid"}, 64'(ic.rsp_valid), 64'(1));
    chk({tag, ".rdata"}, 64'(ic.rsp_rdata), 64'(exp_d));
    chk({tag, ".err"},   64'(ic.rsp_err),   64'(0));
  endtask

  initial begin
    logic [31:0] vals [4];
    logic        exp_v;
    vals[0] = 32'h1111_1111; vals[1] = 32'h2222_2222;
    vals[2] = 32'h3333_3333; vals[3] = 32'h4444_4444;
    vectors = 0; miscompares = 0;
    aresetn = 1'b0;
    ia.req_valid = 0; ia.req_we = 0; ia.req_addr = '0; ia.req_size = 0; ia.req_unsigned = 0; ia.req_wdata = '0;
    ib.req_valid = 0; ib.req_we = 0; ib.req_addr = '0; ib.req_size = 0; ib.req_unsigned = 0; ib.req_wdata = '0;
    ic.req_valid = 0; ic.req_we = 0; ic.req_addr = '0; ic.req_size = 0; ic.req_unsigned = 0; ic.req_wdata = '0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst.ready", 64'(ia.req_ready), 64'(0));
    chk("rst.valid", 64'(ia.rsp_valid), 64'(0));
    chk("rst.rdata", 64'(ia.rsp_rdata), 64'(0));
    chk("rst.err",   64'(ia.rsp_err),   64'(0));

    // Test 1: INIT lasts exactly 16 edges
    aresetn = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      ia.req_valid = 1'b1; ia.req_we = 1'b1; ia.req_addr = 8'h3C; ia.req_size = 2'b10; ia.req_wdata = 32'hFFFF_FFFF;
      @(negedge clk);
      chk($sformatf("init.ready%0d", k), 64'(ia.req_ready), 64'(k >= 16));
      chk($sformatf("init.valid%0d", k), 64'(ia.rsp_valid), 64'(0));
    end
    ia.req_valid = 1'b0; ia.req_we = 1'b0;
    chk("init.ready_b", 64'(ib.req_ready), 64'(1));
    chk("init.ready_c", 64'(ic.req_ready), 64'(1));
    a_req("t1.lw3c", 1'b0, 8'h3C, 2'b10, 1'b0, 32'h0, 32'h0000_0000, 1'b0);
    @(negedge clk);
    chk("t1.idle.valid", 64'(ia.rsp_valid), 64'(0));
    chk("t1.idle.rdata", 64'(ia.rsp_rdata), 64'(0));

    // Test 2: sub-word loads
    a_req("t2.sw",  1'b1, 8'h08, 2'b10, 1'b0, 32'hDEAD_BEEF, 32'h0, 1'b0);
    a_req("t2.lb",  1'b0, 8'h0B, 2'b00, 1'b0, 32'h0, 32'hFFFF_FFDE, 1'b0);
    a_req("t2.lbu", 1'b0, 8'h09, 2'b00, 1'b1, 32'h0, 32'h0000_00BE, 1'b0);
    a_req("t2.lh",  1'b0, 8'h0A, 2'b01, 1'b0, 32'h0, 32'hFFFF_DEAD, 1'b0);
    a_req("t2.lhu", 1'b0, 8'h08, 2'b01, 1'b1, 32'h0, 32'h0000_BEEF, 1'b0);
    a_req("t2.lwu", 1'b0, 8'h08, 2'b10, 1'b1, 32'h0, 32'hDEAD_BEEF, 1'b0);

    // Test 3: sub-word stores
    a_req("t3.sb",  1'b1, 8'h09, 2'b00, 1'b0, 32'h0000_0012, 32'h0, 1'b0);
    a_req("t3.lw1", 1'b0, 8'h08, 2'b10, 1'b0, 32'h0, 32'hDEAD_12EF, 1'b0);
    a_req("t3.sh",  1'b1, 8'h0A, 2'b01, 1'b0, 32'h0000_5A5A, 32'h0, 1'b0);
    a_req("t3.lw2", 1'b0, 8'h08, 2'b10, 1'b0, 32'h0, 32'h5A5A_12EF, 1'b0);

    // Test 4: error cases
    a_req("t4.lw_mis", 1'b0, 8'h02, 2'b10, 1'b0, 32'h0, 32'h0, 1'b1);
    a_req("t4.sh_mis", 1'b1, 8'h03, 2'b01, 1'b0, 32'h0000_FFFF, 32'h0, 1'b1);
    a_req("t4.lw0",    1'b0, 8'h00, 2'b10, 1'b0, 32'h0, 32'h0, 1'b0);
    a_req("t4.lw_oor", 1'b0, 8'h40, 2'b10, 1'b0, 32'h0, 32'h0, 1'b1);
    a_req("t4.sw_oor", 1'b1, 8'h40, 2'b10, 1'b0, 32'h7777_7777, 32'h0, 1'b1);
    a_req("t4.lw0b",   1'b0, 8'h00, 2'b10, 1'b0, 32'h0, 32'h0, 1'b0);
    a_req("t4.ld32",   1'b0, 8'h00, 2'b11, 1'b0, 32'h0, 32'h0, 1'b1);

    // Test 5: LATENCY=3 back-to-back stores then loads
    for (int k = 0; k < 7; k++) begin
      ib.req_valid = (k < 4); ib.req_we = 1'b1; ib.req_size = 2'b10;
      ib.req_addr = 8'(4 * (k % 4)); ib.req_wdata = vals[k % 4];
      @(posedge clk); @(negedge clk);
      exp_v = (k >= 2) && (k <= 5);
      chk($sformatf("t5.st_valid%0d", k), 64'(ib.rsp_valid), 64'(exp_v));
      chk($sformatf("t5.st_rdata%0d", k), 64'(ib.rsp_rdata), 64'(0));
    end
    for (int k = 0; k < 7; k++) begin
      ib.req_valid = (k < 4); ib.req_we = 1'b0; ib.req_size = 2'b10;
      ib.req_addr = 8'(4 * (k % 4));
      @(posedge clk); @(negedge clk);
      exp_v = (k >= 2) && (k <= 5);
      chk($sformatf("t5.ld_valid%0d", k), 64'(ib.rsp_valid), 64'(exp_v));
      if (exp_v) chk($sformatf("t5.ld_rdata%0d", k), 64'(ib.rsp_rdata), 64'(vals[k-2]));
      else       chk($sformatf("t5.ld_rdata%0d", k), 64'(ib.rsp_rdata), 64'(0));
    end
    ib.req_valid = 1'b0;

    // Test 6: LATENCY=2, reset with loads in flight
    c_req("t6.sw", 1'b1, 8'h10, 2'b10, 32'hCAFE_F00D, 32'h0);
    c_req("t6.lw", 1'b0, 8'h10, 2'b10, 32'h0, 32'hCAFE_F00D);
    ic.req_valid = 1'b1; ic.req_we = 1'b0; ic.req_addr = 8'h10; ic.req_size = 2'b10;
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    ic.req_valid = 1'b0;
    chk("t6.pre.valid", 64'(ic.rsp_valid), 64'(1));
    chk("t6.pre.rdata", 64'(ic.rsp_rdata), 64'(32'hCAFE_F00D));
    #2 aresetn = 1'b0;
    #1;
    chk("t6.rst.valid", 64'(ic.rsp_valid), 64'(0));
    chk("t6.rst.rdata", 64'(ic.rsp_rdata), 64'(0));
    chk("t6.rst.ready", 64'(ic.req_ready), 64'(0));
    @(negedge clk);
    aresetn = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      chk($sformatf("t6.init.valid%0d", k), 64'(ic.rsp_valid), 64'(0));
      if (k >= 15) chk($sformatf("t6.init.ready%0d", k), 64'(ic.req_ready), 64'(k == 16));
    end
    c_req("t6.lw_clr", 1'b0, 8'h10, 2'b10, 32'h0, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/rv32i_data_mem.md
Name: rv32i_data_mem

Overview:
- Next-generation data memory for the rv32i core. Replaces the flat word memory with a byte-addressed, byte-enabled store.
- Adds a req/rsp handshake with a parametrised pipelined read latency.
- Performs RISC-V load/store sub-word handling: LB/LH/LW/LD, unsigned variants, SB/SH/SW/SD. Flags misaligned and out-of-range accesses.
- Sits between the core's MEM stage and the storage array. Clears its own contents sequentially after reset instead of in one cycle.

Parameters:
- DLEN, 32, data word width in bits; legal values 32 or 64.
- DEPTH, 1024, number of DLEN-bit words.
- AW, $clog2(DEPTH*DLEN/8), byte address width.
- LATENCY, 1, request-accept to response cycles; legal range 1..4.
- INIT_CLEAR, 1, 1 = zero the whole array after reset; 0 = contents undefined after reset.

Ports:
- clk  in  1  clock
- aresetn  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request
- req_we  in  1  1 = store, 0 = load
- req_addr  in  AW  byte address
- req_size  in  2  00 byte, 01 half, 10 word, 11 double (DLEN=64 only)
- req_unsigned  in  1  loads: zero-extend when 1, sign-extend when 0
- req_wdata  in  DLEN  store data, right-aligned (LSBs)
- rsp_valid  out  1  response present; always consumed, no backpressure
- rsp_rdata  out  DLEN  load result, extended; 0 for stores and errors
- rsp_err  out  1  misaligned, illegal size or out-of-range access

Behaviour:
- Reset/clock: aresetn asynchronous, active-low; clk rising edge for all state.
- Reset values: req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0. Pipeline valid bits cleared; INIT counter=0.
- FSM has two states, INIT and RUN.
  - Reset enters INIT if INIT_CLEAR=1, else RUN.
  - INIT writes 0 to word[cnt] each cycle, cnt 0..DEPTH-1, with req_ready=0. After writing DEPTH-1 it moves to RUN. INIT takes exactly DEPTH cycles from the first clk edge after reset release.
  - RUN: req_ready=1 every cycle.
- Accept: req_valid && req_ready at an edge.
- Address decode:
  - off = addr[$clog2(DLEN/8)-1:0]
  - widx = addr[AW-1:$clog2(DLEN/8)]
- Error conditions (any sets rsp_err=1):
  - off not a multiple of the access size (2^req_size bytes)
  - req_size=11 with DLEN=32
  - widx >= DEPTH
  - On error: no array write and rsp_rdata=0.
- Store: byte enables cover bytes off .. off+2^size-1. req_wdata low bytes are replicated into those lanes. Commit happens at the accept edge; other bytes are untouched.
- Load:
  - The word is read at the accept edge. The addressed lane is extracted, shifted to the LSBs, then zero- or sign-extended to DLEN.
  - Full-width loads ignore req_unsigned.
- Ordering: single port. A load accepted at edge N+1 sees a store accepted at edge N.
- Response timing:
  - A request accepted at edge N gives rsp_valid=1 in the cycle after edge N+LATENCY-1, i.e. LATENCY cycles after accept.
  - Strictly in order, one response per request, full throughput: back-to-back accepts give back-to-back responses.
  - Stores also respond, with rsp_valid=1 and rdata=0 as an acknowledgement.
  - The result is held in a LATENCY-deep valid/data shift pipeline.
- rsp_valid drops to 0 in any cycle with no response due; rsp_rdata and rsp_err are then 0.
- Reset mid-operation:
  - In-flight responses are discarded immediately: outputs go to reset values asynchronously, and no response for pre-reset requests appears afterwards.
  - Stores already committed remain unless INIT_CLEAR=1 re-clears them.
  - INIT restarts from cnt=0.
- Requests with req_valid=1 during INIT are ignored; it is the requester's job to hold them.

Test Plan:
1. DEPTH=16, INIT_CLEAR=1; release reset -> req_ready=0 for 16 cycles then 1; LW 0x3C -> rdata 0x00000000, err=0.
2. SW 0xDEADBEEF @0x8; then LB 0xB -> 0xFFFFFFDE; LBU 0x9 -> 0x000000BE; LH 0xA -> 0xFFFFDEAD; LHU 0x8 -> 0x0000BEEF.
3. After (2), SB wdata=0x12 @0x9 then LW 0x8 -> 0xDEAD12EF; SH 0x5A5A @0xA, LW 0x8 -> 0x5A5A12EF.
4. LW @0x2 -> err=1, rdata 0; SH @0x3 -> err=1, and a following LW 0x0 is unchanged; LW @0x40 with DEPTH=16 -> err=1; size=11 with DLEN=32 -> err=1.
5. LATENCY=3, four back-to-back loads accepted on edges N..N+3 -> rsp_valid=1 on four consecutive cycles starting 3 cycles after N, data in request order.
6. LATENCY=2, two loads in flight, pulse aresetn low -> rsp_valid=0 at once; after release and INIT, no stale response; the previously stored word reads 0 (INIT_CLEAR=1).
